// File: rtl/key_schedule_seq_pkg.sv
// AES key-schedule shared definitions: key length encoding, FSM states, Nk/Nr lookup, xtime.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package key_schedule_seq_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_ILL = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_128:  return NK_128;
      KL_192:  return NK_192;
      default: return NK_256;
    endcase
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      default: return NR_256;
    endcase
  endfunction

  // Key length in bits; the illegal code maps to a value no build can support.
  function automatic int unsigned key_bits_of(input key_len_e kl);
    case (kl)
      KL_128:  return 32'd128;
      KL_192:  return 32'd192;
      KL_256:  return 32'd256;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_seq_sbox.sv
// AES forward S-box, one byte. Ports: i_byte (in), o_byte (substituted out).
// Latency: combinational.
// Backpressure: none.
module key_schedule_seq_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x,3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX_TBL[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/key_schedule_seq.sv
// AES-128/192/256 key expansion, one word per cycle, into a readable round-key store.
// Ports: clk/rst_n; start+key_len+key request; busy/done/err/keys_valid/nr status; rk_idx -> rk_out read.
// Latency: done 41/47/53 edges after acceptance; start is ignored (no backpressure) while busy.
module key_schedule_seq
  import key_schedule_seq_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    keys_valid,
  output logic [3:0]              nr,
  input  logic [3:0]              rk_idx,
  output logic [127:0]            rk_out
);

  localparam int          MAXW       = MAX_KEY_BITS / 32;
  localparam int          WORDS      = 4 * (MAXW + 7);
  localparam int          IW         = $clog2(WORDS);
  localparam int unsigned MAX_BITS_U = MAX_KEY_BITS;

  state_e                  r_state;
  logic [3:0]              r_nk;
  logic [3:0]              r_nr;
  logic [IW-1:0]           r_i;
  logic [2:0]              r_mod;   // i mod Nk, kept as a wrapping counter
  logic [7:0]              r_rcon;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    r_valid;
  logic [MAX_KEY_BITS-1:0] r_key;
  logic [31:0]             r_words [WORDS];

  key_len_e      w_kl;
  logic          w_legal;
  logic          w_accept;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [IW-1:0] w_last_i;
  logic          w_final;

  assign w_kl     = key_len_e'(key_len);
  assign w_legal  = (w_kl != KL_ILL) && (key_bits_of(w_kl) <= MAX_BITS_U);
  assign w_accept = (r_state == ST_IDLE) && start && w_legal;

  assign w_prev   = r_words[r_i - IW'(1)];
  assign w_back   = r_words[r_i - IW'(r_nk)];
  // RotWord only on the Nk-aligned word; the shared SubWord serves both cases.
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_schedule_seq_sbox u_sbox (
      .i_byte(w_sub_in[8*g +: 8]),
      .o_byte(w_sub[8*g +: 8])
    );
  end

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h0};
    end else if ((r_nk == NK_256) && (r_mod == 3'd4)) begin
      w_temp = w_sub;
    end
  end

  assign w_new    = w_back ^ w_temp;
  assign w_last_i = IW'({r_nr, 2'b00}) + IW'(3);
  assign w_final  = (r_state == ST_EXPAND) && (r_i == w_last_i);

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_nk    <= 4'd0;
      r_nr    <= 4'd0;
      r_i     <= '0;
      r_mod   <= 3'd0;
      r_rcon  <= 8'h01;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_LOAD;
            r_nk    <= nk_of(w_kl);
            r_nr    <= nr_of(w_kl);
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_EXPAND;
          r_i     <= IW'(r_nk);
          r_mod   <= 3'd0;
        end
        ST_EXPAND: begin
          r_i   <= r_i + IW'(1);
          r_mod <= (r_mod == 3'(r_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          if (w_final) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Key capture and word store; contents are don't-care until keys_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_key <= key;
    end
    if (r_state == ST_LOAD) begin
      for (int j = 0; j < MAXW; j++) begin
        if (j < int'(r_nk)) begin
          r_words[j] <= r_key[MAX_KEY_BITS-1-32*j -: 32];
        end
      end
    end
    if (r_state == ST_EXPAND) begin
      r_words[r_i] <= w_new;
    end
  end

  always_comb begin
    rk_out = '0;
    if (r_valid && (rk_idx <= r_nr)) begin
      for (int j = 0; j < 4; j++) begin
        if (4 * int'(rk_idx) + j < WORDS) begin
          rk_out[127-32*j -: 32] = r_words[IW'(4 * int'(rk_idx) + j)];
        end
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign keys_valid = r_valid;
  assign nr         = r_nr;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 vectors, random keys against a GF(2^8) reference model.
// Latency: checks done on edge 41/47/53 after acceptance.
// Backpressure: checks that start is ignored while busy.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         busy, done, err, keys_valid;
  logic [3:0]   nr;
  logic [3:0]   rk_idx = 4'd0;
  logic [127:0] rk_out;

  int total = 0;
  int bad = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  int          m_nr;

  always #50 clk = ~clk;

  key_schedule_seq #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid), .nr(nr),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // GF(2^8) arithmetic used to derive the S-box from its definition.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else repeat (254) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Rcon for the n-th Nk-aligned word is x^(n-1).
  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int q = 1; q < n; q++) r = gmul(r, 8'h02);
    return r;
  endfunction

  task automatic model_expand(input logic [255:0] k, input int kl);
    int nk;
    logic [31:0] t;
    nk = 4 + 2 * kl;
    m_nr = nk + 6;
    for (int i = 0; i < 4 * (m_nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = k[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) t = subword({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
        else if (nk == 8 && i % nk == 4) t = subword(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  // Called at a negedge; returns with the DUT idle, again at a negedge.
  task automatic run(input logic [255:0] k, input int kl, input int dup_at,
                     output int done_edge, output int done_cnt);
    done_edge = -1;
    done_cnt = 0;
    key = k;
    key_len = 2'(kl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      start = (n == dup_at);
      if (n == dup_at) begin
        key = ~k;
        key_len = 2'd2;
      end else begin
        key = k;
        key_len = 2'(kl);
      end
      if (n == 1) begin
        check("busy_running", {127'd0, busy}, 128'd1);
        check("valid_cleared", {127'd0, keys_valid}, 128'd0);
      end
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_sched(input string tag, input int exp_edge, input int de, input int dc);
    check({tag, "_done_edge"}, 128'(de), 128'(exp_edge));
    check({tag, "_done_pulses"}, 128'(dc), 128'd1);
    check({tag, "_valid"}, {127'd0, keys_valid}, 128'd1);
    check({tag, "_busy_idle"}, {127'd0, busy}, 128'd0);
    check({tag, "_nr"}, {124'd0, nr}, 128'(m_nr));
    for (int r = 0; r <= m_nr; r++) begin
      rk_idx = 4'(r);
      #1;
      check({tag, "_rk"}, rk_out, {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    end
    rk_idx = 4'(m_nr + 1);
    #1;
    check({tag, "_rk_beyond_nr"}, rk_out, 128'd0);
  endtask

  initial begin
    int de, dc;
    logic [255:0] k128, k192, k256, kr;
    logic [127:0] saved;

    for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));

    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff_ffff_ffff_ffff};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // Reset state
    #10;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_valid", {127'd0, keys_valid}, 128'd0);
    check("rst_nr", {124'd0, nr}, 128'd0);
    check("rst_rk", rk_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 known vector
    run(k128, 0, 0, de, dc);
    model_expand(k128, 0);
    check_sched("aes128", 41, de, dc);
    rk_idx = 4'd10;
    #1;
    check("aes128_fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192 known vector
    @(negedge clk);
    run(k192, 1, 0, de, dc);
    model_expand(k192, 1);
    check_sched("aes192", 47, de, dc);
    rk_idx = 4'd12;
    #1;
    check("aes192_fips_rk12", rk_out, 128'he98ba06f448c773c8ecc720401002202);
    saved = rk_out;

    // Illegal key_len: err pulse, schedule retained
    @(negedge clk);
    key_len = 2'd3;
    key = ~k192;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ill_err_pulse", {127'd0, err}, 128'd1);
    check("ill_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    check("ill_err_cleared", {127'd0, err}, 128'd0);
    check("ill_busy_after", {127'd0, busy}, 128'd0);
    check("ill_valid_kept", {127'd0, keys_valid}, 128'd1);
    check("ill_nr_kept", {124'd0, nr}, 128'd12);
    check("ill_rk_kept", rk_out, saved);

    // AES-256 known vector
    @(negedge clk);
    run(k256, 2, 0, de, dc);
    model_expand(k256, 2);
    check_sched("aes256", 53, de, dc);
    rk_idx = 4'd14;
    #1;
    check("aes256_fips_rk14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);
    rk_idx = 4'd15;
    #1;
    check("aes256_rk15_zero", rk_out, 128'd0);

    // Second start while busy is ignored
    @(negedge clk);
    run(k128, 0, 20, de, dc);
    model_expand(k128, 0);
    check_sched("dup_start", 41, de, dc);
    rk_idx = 4'd10;
    #1;
    check("dup_fips_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Random keys, all three lengths
    for (int t = 0; t < 6; t++) begin
      kr = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      run(kr, t % 3, 0, de, dc);
      model_expand(kr, t % 3);
      check_sched("random", 41 + 6 * (t % 3), de, dc);
    end

    // Reset during EXPAND, then an AES-256 run from the first edge after release
    @(negedge clk);
    key = k128;
    key_len = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_busy", {127'd0, busy}, 128'd1);
    rk_idx = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_done", {127'd0, done}, 128'd0);
    check("midrst_err", {127'd0, err}, 128'd0);
    check("midrst_valid", {127'd0, keys_valid}, 128'd0);
    check("midrst_nr", {124'd0, nr}, 128'd0);
    check("midrst_rk", rk_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(k256, 2, 0, de, dc);
    model_expand(k256, 2);
    check_sched("post_rst", 53, de, dc);
    rk_idx = 4'd14;
    #1;
    check("post_rst_fips_rk14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256, meaning the largest supported key length: 128, 192 or 256; it sizes the key port and the word store.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request expansion; accepted only in IDLE.
REQ-005 SHALL have port key_len, input, 2: key length, where 0=128, 1=192, 2=256 and 3 is illegal; sampled on acceptance.
REQ-006 SHALL have port key, input, MAX_KEY_BITS: the cipher key, MSB-aligned; bits below the selected length are ignored.
REQ-007 SHALL have port busy, output, 1: high in LOAD or EXPAND.
REQ-008 SHALL have port done, output, 1: a one-cycle pulse on completion.
REQ-009 SHALL have port err, output, 1: a one-cycle pulse when start arrives with an illegal or unsupported key_len.
REQ-010 SHALL have port keys_valid, output, 1: high while a complete schedule is stored.
REQ-011 SHALL have port nr, output, 4: round count of the stored schedule, 10, 12 or 14.
REQ-012 SHALL have port rk_idx, input, 4: round-key select.
REQ-013 SHALL have port rk_out, output, 128: round key {w[4r],w[4r+1],w[4r+2],w[4r+3]} for r=rk_idx; combinational read.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and EXPAND.
- IDLE->LOAD on start with a legal key_len.
- LOAD->EXPAND after exactly 1 cycle.
- EXPAND->IDLE on the edge that writes the final word.
REQ-015 SHALL, on acceptance, latch key_len, set Nk=4/6/8 and Nr=10/12/14, clear keys_valid, and set rcon to 8'h01.
REQ-016 SHALL in LOAD write key words w[0..Nk-1] to the word store in one cycle.
REQ-017 SHALL in EXPAND produce one word per cycle, i=Nk..4(Nr+1)-1, per FIPS-197:
- i mod Nk==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}, then rcon advances by xtime (0x80->0x1b).
- Nk==8 and i mod Nk==4: temp=SubWord(w[i-1]).
- otherwise: temp=w[i-1].
- w[i]=w[i-Nk]^temp.
REQ-018 SHALL track i mod Nk with a wrapping counter, using no divider.
REQ-019 SHALL assert done, with keys_valid high, on the 41st/47th/53rd rising edge after the accepting edge for 128/192/256.
REQ-020 SHALL ignore start while busy; the current schedule continues unaffected.
REQ-021 SHALL, on start with key_len=3, or with a length greater than MAX_KEY_BITS, pulse err, remain in IDLE, and leave keys_valid and the store unchanged.
REQ-022 SHALL drive rk_out to 128'h0 when keys_valid is low or rk_idx>nr.
REQ-023 SHALL hold the stored schedule and keys_valid indefinitely until the next accepted start or reset.

Reset
REQ-024 SHALL, while rst_n is low, immediately force:
- state=IDLE; busy, done, err, keys_valid = 0;
- nr=0; rk_out=0; counters=0; rcon=8'h01.
The word store need not be cleared.
REQ-025 SHALL abandon any expansion on reset mid-operation; after release, the block accepts a new start on the first edge.

Structure
REQ-026 SHALL place in a shared package: the key_len encoding enum, the state enum, the Nk/Nr lookup constants, and the xtime function.
REQ-027 SHALL reuse the existing sbox module, instantiated 4 times for one SubWord datapath shared across all rounds.
REQ-028 SHALL size the word store at 4*(MAX_KEY_BITS/32+7) words: 44, 52 or 60.

Verification
REQ-029 SHALL check AES-128 with key 2b7e151628aed2a6abf7158809cf4f3c: rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, done on edge 41, nr=10.
REQ-030 SHALL check AES-192 with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk_idx=12 -> e98ba06f448c773c8ecc720401002202, done on edge 47.
REQ-031 SHALL check AES-256 with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: rk_idx=14 -> fe4890d1e6188d0b046df344706c631e, done on edge 53.
REQ-032 SHALL check a second start pulsed at cycle 20 of an AES-128 run: it is ignored, and the results are identical to REQ-029.
REQ-033 SHALL check start with key_len=3: err=1 for one cycle, busy stays 0, and the previous keys_valid and rk_out are retained.
REQ-034 SHALL check rst_n low at EXPAND cycle 15: outputs go to 0 immediately, then a subsequent AES-256 run matches REQ-031.
